// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared bus command encodings, tag-owner types and widths for the memory arbiter
package mem_bus_arbiter_pkg;
    localparam int XLEN      = 32;
    localparam int MEM_TAG_W = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic {
        OWNER_IC = 1'b0,
        OWNER_DC = 1'b1
    } ARB_OWNER;

    typedef struct packed {
        logic     valid;
        ARB_OWNER owner;
        logic     squashed;
    } ARB_TAG_ENTRY;
endpackage

// File: rtl/arb_tag_table.sv
// arb_tag_table: per-tag owner table with one write, one clear, one lookup port and flush-squash
module arb_tag_table
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_TAGS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 wr_en,
    input  logic [MEM_TAG_W-1:0] wr_tag,
    input  ARB_TAG_ENTRY         wr_entry,
    input  logic                 clr_en,
    input  logic [MEM_TAG_W-1:0] clr_tag,
    input  logic [MEM_TAG_W-1:0] lookup_tag,
    output ARB_TAG_ENTRY         lookup_entry
);
    ARB_TAG_ENTRY tags_q [NUM_TAGS];

    assign lookup_entry = tags_q[lookup_tag];

    // Squash live IC entries first, then clear the returning tag, then record the new grant so a same-tag re-grant survives
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_TAGS; i++) tags_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_TAGS; i++)
                if (flush && tags_q[i].valid && tags_q[i].owner == OWNER_IC) tags_q[i].squashed <= 1'b1;
            if (clr_en) tags_q[clr_tag] <= '0;
            if (wr_en) tags_q[wr_tag] <= wr_entry;
        end
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the tagged memory port between I-cache and D-cache miss paths; ARB_PERF_CNT_EN adds grant/drop counters
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_TAGS     = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ic_req_valid_i,
    input  logic [XLEN-1:0]      ic_req_addr_i,
    output logic                 ic_grant_o,
    input  logic                 ic_flush_i,
    output logic                 ic_resp_valid_o,
    output logic [63:0]          ic_resp_data_o,
    input  logic                 dc_req_valid_i,
    input  logic [1:0]           dc_req_cmd_i,
    input  logic [XLEN-1:0]      dc_req_addr_i,
    input  logic [63:0]          dc_req_data_i,
    output logic                 dc_grant_o,
    output logic [MEM_TAG_W-1:0] dc_grant_tag_o,
    output logic                 dc_resp_valid_o,
    output logic [63:0]          dc_resp_data_o,
    output logic [MEM_TAG_W-1:0] dc_resp_tag_o,
    output logic [1:0]           proc2mem_command_o,
    output logic [XLEN-1:0]      proc2mem_addr_o,
    output logic [63:0]          proc2mem_data_o,
    input  logic [MEM_TAG_W-1:0] mem2proc_response_i,
    input  logic [63:0]          mem2proc_data_i,
    input  logic [MEM_TAG_W-1:0] mem2proc_tag_i
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]          ic_grant_cnt_o,
    output logic [31:0]          dc_grant_cnt_o,
    output logic [31:0]          squash_drop_cnt_o
`endif
);
    logic [2:0]   starve;
    logic         dc_wins, ic_wins, accepted, hit, wr_en, squash_drop;
    ARB_TAG_ENTRY hit_entry, wr_entry;

    // Pick the winner and drive the memory port; D-side wins unless the I-side has starved long enough
    always_comb begin
        dc_wins            = dc_req_valid_i && !(ic_req_valid_i && starve >= 3'(STARVE_LIMIT));
        ic_wins            = ic_req_valid_i && !dc_wins;
        accepted           = mem2proc_response_i != '0;
        dc_grant_o         = dc_wins && accepted;
        ic_grant_o         = ic_wins && accepted;
        dc_grant_tag_o     = dc_grant_o ? mem2proc_response_i : '0;
        proc2mem_command_o = dc_wins ? dc_req_cmd_i : ic_wins ? BUS_LOAD : BUS_NONE;
        proc2mem_addr_o    = dc_wins ? dc_req_addr_i : ic_wins ? ic_req_addr_i : '0;
        proc2mem_data_o    = dc_wins ? dc_req_data_i : '0;
        wr_en              = ic_grant_o || (dc_grant_o && dc_req_cmd_i == BUS_LOAD);
        wr_entry           = '{valid: 1'b1, owner: dc_grant_o ? OWNER_DC : OWNER_IC, squashed: ic_grant_o && ic_flush_i};
    end

    // Route a returning tag to its recorded owner; squashed or flush-cycle IC data is dropped
    always_comb begin
        hit             = mem2proc_tag_i != '0 && hit_entry.valid;
        ic_resp_valid_o = hit && hit_entry.owner == OWNER_IC && !hit_entry.squashed && !ic_flush_i;
        dc_resp_valid_o = hit && hit_entry.owner == OWNER_DC;
        squash_drop     = hit && hit_entry.owner == OWNER_IC && (hit_entry.squashed || ic_flush_i);
        dc_resp_tag_o   = dc_resp_valid_o ? mem2proc_tag_i : '0;
        ic_resp_data_o  = mem2proc_data_i;
        dc_resp_data_o  = mem2proc_data_i;
    end

    // Count consecutive cycles the I-side waits ungranted, saturating at the counter's maximum
    always_ff @(posedge clk) begin
        if (!reset || !ic_req_valid_i || ic_grant_o) starve <= '0;
        else if (starve != 3'h7) starve <= starve + 3'h1;
    end

    arb_tag_table #(.NUM_TAGS(NUM_TAGS)) u_tag_table (
        .clk          (clk),
        .reset        (reset),
        .flush        (ic_flush_i),
        .wr_en        (wr_en),
        .wr_tag       (mem2proc_response_i),
        .wr_entry     (wr_entry),
        .clr_en       (hit),
        .clr_tag      (mem2proc_tag_i),
        .lookup_tag   (mem2proc_tag_i),
        .lookup_entry (hit_entry)
    );

`ifdef ARB_PERF_CNT_EN
    // Free-running wrap-around event counters for grants and dropped squashed responses
    always_ff @(posedge clk) begin
        if (!reset) begin
            ic_grant_cnt_o    <= '0;
            dc_grant_cnt_o    <= '0;
            squash_drop_cnt_o <= '0;
        end else begin
            ic_grant_cnt_o    <= ic_grant_cnt_o + 32'(ic_grant_o);
            dc_grant_cnt_o    <= dc_grant_cnt_o + 32'(dc_grant_o);
            squash_drop_cnt_o <= squash_drop_cnt_o + 32'(squash_drop);
        end
    end
`else
    logic unused_drop;
    assign unused_drop = squash_drop;
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        ic_req_valid_i, ic_flush_i, dc_req_valid_i;
    logic [31:0] ic_req_addr_i, dc_req_addr_i, proc2mem_addr_o;
    logic [1:0]  dc_req_cmd_i, proc2mem_command_o;
    logic [63:0] dc_req_data_i, mem2proc_data_i, ic_resp_data_o, dc_resp_data_o, proc2mem_data_o;
    logic [3:0]  mem2proc_response_i, mem2proc_tag_i, dc_grant_tag_o, dc_resp_tag_o;
    logic        ic_grant_o, ic_resp_valid_o, dc_grant_o, dc_resp_valid_o;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] ic_grant_cnt_o, dc_grant_cnt_o, squash_drop_cnt_o;
`endif
    int errors = 0;
    int checks = 0;

    localparam logic [1:0] NONE = 2'h0, LOAD = 2'h1, STORE = 2'h2;

    mem_bus_arbiter dut (
        .clk                 (clk),
        .reset               (reset),
        .ic_req_valid_i      (ic_req_valid_i),
        .ic_req_addr_i       (ic_req_addr_i),
        .ic_grant_o          (ic_grant_o),
        .ic_flush_i          (ic_flush_i),
        .ic_resp_valid_o     (ic_resp_valid_o),
        .ic_resp_data_o      (ic_resp_data_o),
        .dc_req_valid_i      (dc_req_valid_i),
        .dc_req_cmd_i        (dc_req_cmd_i),
        .dc_req_addr_i       (dc_req_addr_i),
        .dc_req_data_i       (dc_req_data_i),
        .dc_grant_o          (dc_grant_o),
        .dc_grant_tag_o      (dc_grant_tag_o),
        .dc_resp_valid_o     (dc_resp_valid_o),
        .dc_resp_data_o      (dc_resp_data_o),
        .dc_resp_tag_o       (dc_resp_tag_o),
        .proc2mem_command_o  (proc2mem_command_o),
        .proc2mem_addr_o     (proc2mem_addr_o),
        .proc2mem_data_o     (proc2mem_data_o),
        .mem2proc_response_i (mem2proc_response_i),
        .mem2proc_data_i     (mem2proc_data_i),
        .mem2proc_tag_i      (mem2proc_tag_i)
`ifdef ARB_PERF_CNT_EN
        ,
        .ic_grant_cnt_o      (ic_grant_cnt_o),
        .dc_grant_cnt_o      (dc_grant_cnt_o),
        .squash_drop_cnt_o   (squash_drop_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ic_req_valid_i = 0; ic_req_addr_i = 0; ic_flush_i = 0;
        dc_req_valid_i = 0; dc_req_cmd_i = NONE; dc_req_addr_i = 0; dc_req_data_i = 0;
        mem2proc_response_i = 0; mem2proc_data_i = 0; mem2proc_tag_i = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        reset = 0;
        idle();
        settle();
        check("rst_cmd", 64'(proc2mem_command_o), 64'(NONE));
        check("rst_addr", 64'(proc2mem_addr_o), 0);
        check("rst_grants", {62'b0, ic_grant_o, dc_grant_o}, 0);
        check("rst_resp", {62'b0, ic_resp_valid_o, dc_resp_valid_o}, 0);
        next(); next();
        reset = 1;

        // both request: data side wins
        ic_req_valid_i = 1; ic_req_addr_i = 32'h200;
        dc_req_valid_i = 1; dc_req_cmd_i = LOAD; dc_req_addr_i = 32'h100; mem2proc_response_i = 3;
        settle();
        check("t1_dc_grant", 64'(dc_grant_o), 1);
        check("t1_dc_tag", 64'(dc_grant_tag_o), 3);
        check("t1_ic_grant", 64'(ic_grant_o), 0);
        check("t1_cmd", 64'(proc2mem_command_o), 64'(LOAD));
        check("t1_addr", 64'(proc2mem_addr_o), 64'h100);
        next(); next();
        mem2proc_tag_i = 3; mem2proc_data_i = 64'hDEAD;
        settle();
        check("t1_dc_resp", 64'(dc_resp_valid_o), 1);
        check("t1_dc_resp_tag", 64'(dc_resp_tag_o), 3);
        check("t1_dc_data", dc_resp_data_o, 64'hDEAD);
        check("t1_ic_resp", 64'(ic_resp_valid_o), 0);
        next();
        mem2proc_tag_i = 3;
        settle();
        check("t1_cleared", 64'(dc_resp_valid_o), 0);
        next();

        // starvation: ic wins on the 5th consecutive cycle
        for (int c = 0; c < 6; c++) begin
            ic_req_valid_i = 1; ic_req_addr_i = 32'h300;
            dc_req_valid_i = 1; dc_req_cmd_i = LOAD; dc_req_addr_i = 32'h400;
            mem2proc_response_i = 4'(8 + c);
            settle();
            check($sformatf("t2_ic_grant_c%0d", c), 64'(ic_grant_o), (c == 4) ? 1 : 0);
            check($sformatf("t2_dc_grant_c%0d", c), 64'(dc_grant_o), (c == 4) ? 0 : 1);
            if (c == 4) check("t2_ic_addr", 64'(proc2mem_addr_o), 64'h300);
            next();
        end

        // store issues with data but records nothing
        dc_req_valid_i = 1; dc_req_cmd_i = STORE; dc_req_addr_i = 32'h500;
        dc_req_data_i = 64'h1122334455667788; mem2proc_response_i = 4;
        settle();
        check("t3_st_grant", 64'(dc_grant_o), 1);
        check("t3_st_cmd", 64'(proc2mem_command_o), 64'(STORE));
        check("t3_st_data", proc2mem_data_o, 64'h1122334455667788);
        next();
        mem2proc_tag_i = 4;
        settle();
        check("t3_st_noresp", {62'b0, ic_resp_valid_o, dc_resp_valid_o}, 0);
        next();

        // flush squashes outstanding ic tag 5
        ic_req_valid_i = 1; ic_req_addr_i = 32'h600; mem2proc_response_i = 5;
        settle();
        check("t4_ic_grant", 64'(ic_grant_o), 1);
        check("t4_dc_tag0", 64'(dc_grant_tag_o), 0);
        next();
        ic_flush_i = 1;
        next();
        mem2proc_tag_i = 5; mem2proc_data_i = 64'h1234;
        settle();
        check("t4_squashed", 64'(ic_resp_valid_o), 0);
        next();
        mem2proc_tag_i = 5;
        settle();
        check("t4_cleared", {62'b0, ic_resp_valid_o, dc_resp_valid_o}, 0);
        next();
        ic_req_valid_i = 1; mem2proc_response_i = 5;
        next();
        mem2proc_tag_i = 5; mem2proc_data_i = 64'h5555;
        settle();
        check("t4_regrant_resp", 64'(ic_resp_valid_o), 1);
        check("t4_regrant_data", ic_resp_data_o, 64'h5555);
        next();

        // grant in the flush cycle is recorded squashed
        ic_req_valid_i = 1; ic_flush_i = 1; mem2proc_response_i = 14;
        settle();
        check("t5_flush_grant", 64'(ic_grant_o), 1);
        next();
        mem2proc_tag_i = 14;
        settle();
        check("t5_flush_grant_drop", 64'(ic_resp_valid_o), 0);
        next();

        // response arriving in the flush cycle is suppressed
        ic_req_valid_i = 1; mem2proc_response_i = 6;
        next();
        mem2proc_tag_i = 6; ic_flush_i = 1;
        settle();
        check("t6_flush_cycle", 64'(ic_resp_valid_o), 0);
        next();

        // same tag returns to dc and is re-granted to ic
        dc_req_valid_i = 1; dc_req_cmd_i = LOAD; mem2proc_response_i = 7;
        next();
        mem2proc_tag_i = 7; mem2proc_data_i = 64'h77;
        ic_req_valid_i = 1; ic_req_addr_i = 32'h700; mem2proc_response_i = 7;
        settle();
        check("t7_old_dc", 64'(dc_resp_valid_o), 1);
        check("t7_old_tag", 64'(dc_resp_tag_o), 7);
        check("t7_ic_grant", 64'(ic_grant_o), 1);
        check("t7_no_ic", 64'(ic_resp_valid_o), 0);
        next();
        mem2proc_tag_i = 7; mem2proc_data_i = 64'h88;
        settle();
        check("t7_new_ic", 64'(ic_resp_valid_o), 1);
        check("t7_new_dc", 64'(dc_resp_valid_o), 0);
        next();

        // retries: no grant while response is 0
        for (int c = 0; c < 4; c++) begin
            dc_req_valid_i = 1; dc_req_cmd_i = LOAD; dc_req_addr_i = 32'h800;
            mem2proc_response_i = (c == 3) ? 4'd2 : 4'd0;
            settle();
            check($sformatf("t8_grant_c%0d", c), 64'(dc_grant_o), (c == 3) ? 1 : 0);
            check($sformatf("t8_gtag_c%0d", c), 64'(dc_grant_tag_o), (c == 3) ? 2 : 0);
            next();
        end
        mem2proc_tag_i = 2;
        settle();
        check("t8_resp", 64'(dc_resp_valid_o), 1);
        next();

        // reset with tags 1 (dc) and 2 (ic) outstanding
        dc_req_valid_i = 1; dc_req_cmd_i = LOAD; mem2proc_response_i = 1;
        next();
        ic_req_valid_i = 1; mem2proc_response_i = 2;
        next();
        reset = 0;
        next();
        reset = 1;
        mem2proc_tag_i = 1;
        settle();
        check("t9_tag1", {62'b0, ic_resp_valid_o, dc_resp_valid_o}, 0);
        next();
        mem2proc_tag_i = 2;
        settle();
        check("t9_tag2", {62'b0, ic_resp_valid_o, dc_resp_valid_o}, 0);
        next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single tagged memory port (proc2mem/mem2proc) between the instruction-cache miss path that feeds fetch and the data-cache miss/writeback path.
- Arbitrates requests and issues the winner to memory.
- Records which requester owns each outstanding memory tag, then routes returning data to that owner.
- Supports squashing in-flight instruction fetches on a taken branch, so stale lines never reach the fetch buffer.

Parameters:
NUM_TAGS, 16, number of memory tags; tag 0 is reserved and means "no tag".
STARVE_LIMIT, 4, consecutive cycles an instruction request may lose before it takes priority.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset; state clears on a rising clk edge while reset==0
ic_req_valid_i  in  1  instruction-side read request
ic_req_addr_i  in  XLEN  8-byte-aligned read address
ic_grant_o  out  1  instruction request accepted by memory this cycle
ic_flush_i  in  1  squash all outstanding instruction reads (taken branch)
ic_resp_valid_o  out  1  instruction data valid
ic_resp_data_o  out  64  instruction data
dc_req_valid_i  in  1  data-side request
dc_req_cmd_i  in  2  BUS_LOAD or BUS_STORE
dc_req_addr_i  in  XLEN  8-byte-aligned address
dc_req_data_i  in  64  store data
dc_grant_o  out  1  data request accepted this cycle
dc_grant_tag_o  out  4  tag assigned to the accepted data load
dc_resp_valid_o  out  1  data load response valid
dc_resp_data_o  out  64  load data
dc_resp_tag_o  out  4  tag of the returning load
proc2mem_command_o  out  2  BUS_NONE, BUS_LOAD or BUS_STORE
proc2mem_addr_o  out  XLEN  memory address
proc2mem_data_o  out  64  store data
mem2proc_response_i  in  4  nonzero = request accepted, value is its tag
mem2proc_data_i  in  64  returning data
mem2proc_tag_i  in  4  nonzero = data for this tag is present

Behaviour:
- Issue is combinational within a cycle. The winner drives proc2mem_*. With no requester, command=BUS_NONE and addr/data=0.
- Priority: data side wins by default. Instruction side wins when its starvation counter has reached STARVE_LIMIT.
- Starvation counter (3 bits):
  - increments, saturating, each cycle ic_req_valid_i=1 and the instruction side is not granted;
  - clears on an instruction grant or when ic_req_valid_i=0.
- Grant: winner's grant is driven high only if mem2proc_response_i!=0 in the same cycle. Response 0 = retry: no grant, nothing recorded.
- Owner table: NUM_TAGS entries of {valid, owner(0=IC,1=DC), squashed}. A granted BUS_LOAD writes entry[mem2proc_response_i] <= {1, owner, 0}. Stores are not recorded; they have no data return.
- Response routing, when mem2proc_tag_i!=0 and that entry is valid:
  - owner IC and not squashed: ic_resp_valid_o=1;
  - owner DC: dc_resp_valid_o=1 with dc_resp_tag_o=tag;
  - squashed: dropped, no valid asserted.
  - In every case the entry is cleared at the clock edge.
- Response data outputs pass mem2proc_data_i through combinationally; the valid outputs are zero-latency.
- Response tag of an invalid entry: ignored, no valid, table unchanged.
- Same tag returned and re-granted in the same cycle: the clear is applied first, then the new write. The new entry is valid and the old response is routed normally.
- ic_flush_i=1: every valid IC entry gets squashed<=1. An IC grant in the same cycle is recorded as squashed. An IC response arriving in the flush cycle is suppressed (ic_resp_valid_o=0).
- dc_grant_tag_o equals mem2proc_response_i when dc_grant_o=1, else 0.
- Reset (reset==0): table cleared, counter=0. All outputs are combinational from inputs and table state, so during reset they follow the inputs with an empty table. Responses that return after reset find invalid entries and are dropped. Reset mid-transfer is safe.

Optional Feature:
Macro ARB_PERF_CNT_EN.
- Defined: adds outputs ic_grant_cnt_o, dc_grant_cnt_o, squash_drop_cnt_o (32 bits each, reset to 0, wrap on overflow), counting grants and dropped squashed responses.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- The shared sys_defs package gains:
  - enum ARB_OWNER {OWNER_IC, OWNER_DC};
  - struct ARB_TAG_ENTRY {valid, owner, squashed};
  - constant MEM_TAG_W=4.
- BUS_LOAD/BUS_STORE/BUS_NONE are reused from the package.
- Sub-module arb_tag_table holds the owner table: one write port, one clear port, one lookup port and a flush-squash input.

Test Plan:
- Both request, dc BUS_LOAD addr 0x100, ic addr 0x200, response=3 → dc_grant_o=1, dc_grant_tag_o=3, ic_grant_o=0. Later tag 3 with data 0xDEAD → dc_resp_valid_o=1, dc_resp_tag_o=3.
- dc requests every cycle while ic waits, STARVE_LIMIT=4 → ic granted on the 5th cycle, counter returns to 0.
- ic granted with tag 5, ic_flush_i pulsed, then tag 5 returns → ic_resp_valid_o=0, entry cleared. A re-grant on tag 5 routes normally afterwards.
- mem2proc_tag_i=7 returns while response=7 re-grants to ic in the same cycle → the old owner gets the data and entry 7 becomes valid for IC.
- mem2proc_response_i=0 for 3 cycles → no grants, table unchanged. Response 2 on the 4th cycle → grant.
- Assert reset=0 with tags 1/2 outstanding, release, return tags 1 and 2 → no resp_valid asserted on either side.
